// File: rtl/vegeta_sparse_macc_if.sv
// Bus bundle for the N:M structured-sparse MAC processing element.
// The driver (array controller or bench) takes the master modport; the PE takes slave.
interface vegeta_sparse_macc_if #(
  parameter int DATA_W     = 8,
  parameter int LANES      = 2,
  parameter int BLOCK      = 4,
  parameter int IDX_W      = (BLOCK > 1) ? $clog2(BLOCK) : 1,
  parameter int ACC_W      = 32,
  parameter int LAST_SUM_W = 32
);
  // A cascade width of 0 still carries a 1-bit unused wire.
  localparam int LS_W = (LAST_SUM_W > 0) ? LAST_SUM_W : 1;

  logic                    enable;
  logic [LANES*DATA_W-1:0] weight_in;
  logic [LANES*IDX_W-1:0]  meta_in;
  logic                    preload_weight;
  logic                    load_weight;
  logic [BLOCK*DATA_W-1:0] in_data;
  logic                    in_valid;
  logic [LS_W-1:0]         last_sum;
  logic [ACC_W-1:0]        partial_sum;
  logic                    out_valid;
  logic                    sat_flag;

  modport master (
    output enable, weight_in, meta_in, preload_weight, load_weight,
    output in_data, in_valid, last_sum,
    input  partial_sum, out_valid, sat_flag
  );

  modport slave (
    input  enable, weight_in, meta_in, preload_weight, load_weight,
    input  in_data, in_valid, last_sum,
    output partial_sum, out_valid, sat_flag
  );
endinterface

// File: rtl/vegeta_sparse_macc.sv
// N:M structured-sparse multiply-accumulate PE.
// LANES stored non-zero weights pick their partner elements out of a dense
// BLOCK-wide input using per-lane metadata indices; the lane products are
// summed with the cascaded partial sum from the PE above. Weights are double
// buffered (shadow/active) and the 3-stage datapath advances only on enable.
module vegeta_sparse_macc #(
  parameter int DATA_W     = 8,
  parameter int LANES      = 2,
  parameter int BLOCK      = 4,
  parameter int IDX_W      = (BLOCK > 1) ? $clog2(BLOCK) : 1,
  parameter int ACC_W      = 32,
  parameter int LAST_SUM_W = 32,
  parameter int SATURATE   = 0
) (
  input logic               clk,
  input logic               reset,
  vegeta_sparse_macc_if.slave bus
);

  localparam int PROD_W = 2 * DATA_W;
  // One guard bit above the accumulator lets overflow be detected exactly.
  localparam int SUM_W  = ACC_W + 1;

  // Parameter sanity: these combinations cannot produce correct results.
  generate
    if (LANES > BLOCK) begin : g_bad_lanes
      $error("vegeta_sparse_macc: LANES must not exceed BLOCK");
    end
    if (ACC_W < 2 * DATA_W + $clog2(LANES) + 1) begin : g_bad_acc
      $error("vegeta_sparse_macc: ACC_W too narrow for LANES products");
    end
    if (LAST_SUM_W > ACC_W) begin : g_bad_cascade
      $error("vegeta_sparse_macc: LAST_SUM_W must not exceed ACC_W");
    end
  endgenerate

  // Sign-extend one lane product to the guarded sum width.
  function automatic logic signed [SUM_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(SUM_W - PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Widen an operand so the multiply is carried out at full product width.
  function automatic logic signed [PROD_W-1:0] widen(input logic signed [DATA_W-1:0] v);
    return {{DATA_W{v[DATA_W-1]}}, v};
  endfunction

  // Reduce the guarded sum to ACC_W bits; returns {clamped, value}.
  function automatic logic [ACC_W:0] saturate_sum(input logic signed [SUM_W-1:0] s);
    logic ovf;
    ovf = s[SUM_W-1] ^ s[SUM_W-2];
    if ((SATURATE != 0) && ovf) begin
      if (s[SUM_W-1]) return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      else            return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    end
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  logic signed [DATA_W-1:0] shadow_w [LANES];
  logic        [IDX_W-1:0]  shadow_m [LANES];
  logic signed [DATA_W-1:0] active_w [LANES];
  logic        [IDX_W-1:0]  active_m [LANES];
  logic signed [DATA_W-1:0] eff_w    [LANES];
  logic        [IDX_W-1:0]  eff_m    [LANES];

  // Double-buffered weight store; runs regardless of enable. When preload and
  // load coincide, active takes the shadow contents from before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        shadow_w[i] <= '0;
        shadow_m[i] <= '0;
        active_w[i] <= '0;
        active_m[i] <= '0;
      end
    end else begin
      if (bus.preload_weight) begin
        for (int i = 0; i < LANES; i++) begin
          shadow_w[i] <= bus.weight_in[i*DATA_W +: DATA_W];
          shadow_m[i] <= bus.meta_in[i*IDX_W +: IDX_W];
        end
      end
      if (bus.load_weight) begin
        for (int i = 0; i < LANES; i++) begin
          active_w[i] <= shadow_w[i];
          active_m[i] <= shadow_m[i];
        end
      end
    end
  end

  // Weights seen by the multiply stage: a load on this very edge already
  // applies to the block being multiplied on it.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      eff_w[i] = bus.load_weight ? shadow_w[i] : active_w[i];
      eff_m[i] = bus.load_weight ? shadow_m[i] : active_m[i];
    end
  end

  // ---- Stage 1: dense input capture ----
  logic signed [DATA_W-1:0] data_p0 [BLOCK];
  logic                     vld_p0;

  // Register the dense block and its valid flag on enabled edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < BLOCK; j++) data_p0[j] <= '0;
      vld_p0 <= 1'b0;
    end else if (bus.enable) begin
      for (int j = 0; j < BLOCK; j++) data_p0[j] <= bus.in_data[j*DATA_W +: DATA_W];
      vld_p0 <= bus.in_valid;
    end
  end

  // ---- Stage 2: metadata select and per-lane multiply ----
  logic signed [DATA_W-1:0] lane_elem [LANES];
  logic signed [PROD_W-1:0] prod_p1   [LANES];
  logic                     vld_p1;

  // Gather each lane's element; an index past the block selects zero.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_elem[i] = '0;
      for (int j = 0; j < BLOCK; j++) begin
        if (int'(eff_m[i]) == j) lane_elem[i] = data_p0[j];
      end
    end
  end

  // Register the signed lane products alongside the valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) prod_p1[i] <= '0;
      vld_p1 <= 1'b0;
    end else if (bus.enable) begin
      for (int i = 0; i < LANES; i++) prod_p1[i] <= widen(eff_w[i]) * widen(lane_elem[i]);
      vld_p1 <= vld_p0;
    end
  end

  // ---- Stage 3: reduction with cascade, overflow handling ----
  logic signed [SUM_W-1:0] cascade_ext;
  logic signed [SUM_W-1:0] sum_full;
  logic        [ACC_W-1:0] partial_sum_p2;
  logic                    sat_p2;
  logic                    vld_p2;

  generate
    if (LAST_SUM_W > 0) begin : g_cascade
      assign cascade_ext = {{(SUM_W - LAST_SUM_W){bus.last_sum[LAST_SUM_W-1]}}, bus.last_sum};
    end else begin : g_first_row
      assign cascade_ext = '0;
    end
  endgenerate

  // Add every lane product to the incoming cascade at guarded width.
  always_comb begin
    sum_full = cascade_ext;
    for (int i = 0; i < LANES; i++) sum_full = sum_full + sext_prod(prod_p1[i]);
  end

  // Register the final (wrapped or clamped) result with its flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      partial_sum_p2 <= '0;
      sat_p2         <= 1'b0;
      vld_p2         <= 1'b0;
    end else if (bus.enable) begin
      {sat_p2, partial_sum_p2} <= saturate_sum(sum_full);
      vld_p2                   <= vld_p1;
    end
  end

  assign bus.partial_sum = partial_sum_p2;
  assign bus.out_valid   = vld_p2;
  assign bus.sat_flag    = sat_p2;

endmodule

// File: tb/tb_vegeta_sparse_macc.sv
// Directed bench for vegeta_sparse_macc: a default-config PE plus two
// 18-bit accumulator PEs (saturating and wrapping) share clock and reset.
module tb_vegeta_sparse_macc;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  vegeta_sparse_macc_if #(.DATA_W(8), .LANES(2), .BLOCK(4), .ACC_W(32), .LAST_SUM_W(32)) if0 ();
  vegeta_sparse_macc_if #(.DATA_W(8), .LANES(2), .BLOCK(4), .ACC_W(18), .LAST_SUM_W(18)) if1 ();
  vegeta_sparse_macc_if #(.DATA_W(8), .LANES(2), .BLOCK(4), .ACC_W(18), .LAST_SUM_W(18)) if2 ();

  vegeta_sparse_macc #(.DATA_W(8), .LANES(2), .BLOCK(4), .ACC_W(32), .LAST_SUM_W(32), .SATURATE(0))
    dut0 (.clk(clk), .reset(reset), .bus(if0));
  vegeta_sparse_macc #(.DATA_W(8), .LANES(2), .BLOCK(4), .ACC_W(18), .LAST_SUM_W(18), .SATURATE(1))
    dut_sat (.clk(clk), .reset(reset), .bus(if1));
  vegeta_sparse_macc #(.DATA_W(8), .LANES(2), .BLOCK(4), .ACC_W(18), .LAST_SUM_W(18), .SATURATE(0))
    dut_wrap (.clk(clk), .reset(reset), .bus(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    if0.enable = 1'b1; if0.preload_weight = 1'b0; if0.load_weight = 1'b0;
    if0.weight_in = '0; if0.meta_in = '0; if0.in_data = '0; if0.in_valid = 1'b0; if0.last_sum = '0;
    if1.enable = 1'b1; if1.preload_weight = 1'b0; if1.load_weight = 1'b0;
    if1.weight_in = '0; if1.meta_in = '0; if1.in_data = '0; if1.in_valid = 1'b0; if1.last_sum = '0;
    if2.enable = 1'b1; if2.preload_weight = 1'b0; if2.load_weight = 1'b0;
    if2.weight_in = '0; if2.meta_in = '0; if2.in_data = '0; if2.in_valid = 1'b0; if2.last_sum = '0;
  endtask

  // Preload then load weights/meta on the default PE.
  task automatic load_w0(input logic signed [7:0] w0, input logic signed [7:0] w1,
                         input logic [1:0] m0, input logic [1:0] m1);
    if0.weight_in = {w1, w0};
    if0.meta_in   = {m1, m0};
    if0.preload_weight = 1'b1;
    tick;
    if0.preload_weight = 1'b0;
    if0.load_weight = 1'b1;
    tick;
    if0.load_weight = 1'b0;
  endtask

  // Push one valid block through the default PE; returns the result seen
  // after the third edge and whether out_valid rose early.
  task automatic run_one(input logic [31:0] data, input logic signed [31:0] last,
                         output logic signed [31:0] ps, output logic ov, output logic ov_early);
    if0.in_data  = data;
    if0.in_valid = 1'b1;
    if0.last_sum = last;
    tick;
    ov_early = if0.out_valid;
    if0.in_valid = 1'b0;
    tick;
    ov_early = ov_early | if0.out_valid;
    tick;
    ps = if0.partial_sum;
    ov = if0.out_valid;
  endtask

  // Load the same weights (meta {0,1}) into both 18-bit PEs.
  task automatic load_sat(input logic [15:0] w);
    if1.weight_in = w; if2.weight_in = w;
    if1.meta_in = 4'b0100; if2.meta_in = 4'b0100;
    if1.preload_weight = 1'b1; if2.preload_weight = 1'b1;
    tick;
    if1.preload_weight = 1'b0; if2.preload_weight = 1'b0;
    if1.load_weight = 1'b1; if2.load_weight = 1'b1;
    tick;
    if1.load_weight = 1'b0; if2.load_weight = 1'b0;
  endtask

  // Push one all -128 block through both 18-bit PEs.
  task automatic sat_block(input logic [17:0] last);
    if1.in_data = 32'h8080_8080; if2.in_data = 32'h8080_8080;
    if1.last_sum = last; if2.last_sum = last;
    if1.in_valid = 1'b1; if2.in_valid = 1'b1;
    tick;
    if1.in_valid = 1'b0; if2.in_valid = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset;
    idle_all;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    checks++; if (if0.partial_sum !== 32'd0) begin errors++; $display("FAIL reset_ps0: got %0d expected 0", if0.partial_sum); end
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov0: got %b expected 0", if0.out_valid); end
    checks++; if (if0.sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat0: got %b expected 0", if0.sat_flag); end
    checks++; if (if1.partial_sum !== 18'd0) begin errors++; $display("FAIL reset_ps1: got %0d expected 0", if1.partial_sum); end
    checks++; if (if1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov1: got %b expected 0", if1.out_valid); end
    checks++; if (if1.sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat1: got %b expected 0", if1.sat_flag); end
    checks++; if (if2.partial_sum !== 18'd0) begin errors++; $display("FAIL reset_ps2: got %0d expected 0", if2.partial_sum); end
    checks++; if (if2.out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov2: got %b expected 0", if2.out_valid); end
  endtask

  task automatic test_basic;
    logic signed [31:0] ps;
    logic ov, ove;
    load_w0(8'sd3, -8'sd2, 2'd0, 2'd2);
    run_one({8'd40, 8'd30, 8'd20, 8'd10}, 32'sd100, ps, ov, ove);
    checks++; if (ove !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", ove); end
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", ov); end
    checks++; if (ps !== 32'sd70) begin errors++; $display("FAIL basic_sum: got %0d expected 70", ps); end
    tick;
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL basic_single_pulse: got %b expected 0", if0.out_valid); end
  endtask

  task automatic test_extremes;
    logic signed [31:0] ps;
    logic ov, ove;
    load_w0(-8'sd128, -8'sd128, 2'd0, 2'd1);
    run_one(32'h8080_8080, 32'sd0, ps, ov, ove);
    checks++; if (ps !== 32'sd32768) begin errors++; $display("FAIL extreme_pos: got %0d expected 32768", ps); end
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL extreme_pos_valid: got %b expected 1", ov); end
    run_one(32'h8080_8080, 32'sh8000_0000, ps, ov, ove);
    checks++; if (ps !== -32'sd2147450880) begin errors++; $display("FAIL extreme_cascade: got %0d expected -2147450880", ps); end
    checks++; if (if0.sat_flag !== 1'b0) begin errors++; $display("FAIL extreme_sat_flag: got %b expected 0", if0.sat_flag); end
  endtask

  task automatic test_saturation;
    // 2*16384 + 131071 = 163839 overflows 18 bits
    load_sat(16'h8080);
    sat_block(18'd131071);
    checks++; if (if1.partial_sum !== 18'd131071) begin errors++; $display("FAIL sat_pos_value: got %0d expected 131071", if1.partial_sum); end
    checks++; if (if1.sat_flag !== 1'b1) begin errors++; $display("FAIL sat_pos_flag: got %b expected 1", if1.sat_flag); end
    checks++; if (if1.out_valid !== 1'b1) begin errors++; $display("FAIL sat_pos_valid: got %b expected 1", if1.out_valid); end
    checks++; if (if2.partial_sum !== 18'd163839) begin errors++; $display("FAIL wrap_pos_value: got %0d expected 163839 (-98305)", if2.partial_sum); end
    checks++; if (if2.sat_flag !== 1'b0) begin errors++; $display("FAIL wrap_pos_flag: got %b expected 0", if2.sat_flag); end
    // in range: 32768, no clamp
    sat_block(18'd0);
    checks++; if (if1.partial_sum !== 18'd32768) begin errors++; $display("FAIL sat_inrange_value: got %0d expected 32768", if1.partial_sum); end
    checks++; if (if1.sat_flag !== 1'b0) begin errors++; $display("FAIL sat_inrange_flag: got %b expected 0", if1.sat_flag); end
    // 2*(-16256) - 131072 = -163584 underflows; clamp to -131072, wrap to 98560
    load_sat(16'h7F7F);
    sat_block(18'h20000);
    checks++; if (if1.partial_sum !== 18'h20000) begin errors++; $display("FAIL sat_neg_value: got %0d expected 131072 (-131072)", if1.partial_sum); end
    checks++; if (if1.sat_flag !== 1'b1) begin errors++; $display("FAIL sat_neg_flag: got %b expected 1", if1.sat_flag); end
    checks++; if (if2.partial_sum !== 18'd98560) begin errors++; $display("FAIL wrap_neg_value: got %0d expected 98560", if2.partial_sum); end
  endtask

  task automatic test_stall;
    logic signed [31:0] got [4];
    logic signed [31:0] exp_v [4];
    int n;
    exp_v[0] = 32'sd3; exp_v[1] = 32'sd8; exp_v[2] = 32'sd13; exp_v[3] = -32'sd3;
    n = 0;
    for (int i = 0; i < 4; i++) got[i] = 'x;
    // result = e0 + 2*e3
    load_w0(8'sd1, 8'sd2, 2'd0, 2'd3);
    if0.in_data = '0; if0.in_valid = 1'b0; if0.last_sum = '0;
    tick; tick; tick;
    if0.in_valid = 1'b1;
    if0.in_data = {8'd1, 8'd0, 8'd0, 8'd1};
    tick;
    if0.in_data = {8'd3, 8'd0, 8'd0, 8'd2};
    tick;
    if0.enable = 1'b0;
    if0.in_data = {8'd4, 8'd0, 8'd0, 8'd5};
    for (int s = 0; s < 2; s++) begin
      tick;
      checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL stall_hold_valid: got %b expected 0", if0.out_valid); end
      checks++; if (if0.partial_sum !== 32'd0) begin errors++; $display("FAIL stall_hold_sum: got %0d expected 0", if0.partial_sum); end
    end
    if0.enable = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 1) if0.in_data = {8'd2, 8'd0, 8'd0, 8'hF9};
      if (k == 2) begin if0.in_valid = 1'b0; if0.in_data = '0; end
      tick;
      if (if0.out_valid === 1'b1) begin
        if (n < 4) got[n] = if0.partial_sum;
        n++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin errors++; $display("FAIL stall_result_%0d: got %0d expected %0d", i, got[i], exp_v[i]); end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL stall_count: got %0d results expected 4", n); end
  endtask

  task automatic test_double_buffer;
    logic signed [31:0] ps;
    logic ov, ove;
    // result = 10*w0 + 20*w1
    load_w0(8'sd1, 8'sd1, 2'd0, 2'd1);
    if0.weight_in = {8'd2, 8'd2};
    if0.preload_weight = 1'b1;
    tick;
    if0.preload_weight = 1'b0;
    run_one({8'd0, 8'd0, 8'd20, 8'd10}, 32'sd0, ps, ov, ove);
    checks++; if (ps !== 32'sd30) begin errors++; $display("FAIL dbuf_preload_only: got %0d expected 30", ps); end
    if0.weight_in = {8'd5, 8'd5};
    if0.preload_weight = 1'b1;
    if0.load_weight = 1'b1;
    tick;
    if0.preload_weight = 1'b0;
    if0.load_weight = 1'b0;
    run_one({8'd0, 8'd0, 8'd20, 8'd10}, 32'sd0, ps, ov, ove);
    checks++; if (ps !== 32'sd60) begin errors++; $display("FAIL dbuf_old_shadow: got %0d expected 60", ps); end
    if0.load_weight = 1'b1;
    tick;
    if0.load_weight = 1'b0;
    run_one({8'd0, 8'd0, 8'd20, 8'd10}, 32'sd0, ps, ov, ove);
    checks++; if (ps !== 32'sd150) begin errors++; $display("FAIL dbuf_second_load: got %0d expected 150", ps); end
  endtask

  task automatic test_reset_inflight;
    load_w0(8'sd1, 8'sd1, 2'd0, 2'd1);
    if0.last_sum = '0;
    if0.in_data = {8'd0, 8'd0, 8'd20, 8'd10};
    if0.in_valid = 1'b1;
    tick;
    tick;
    reset = 1'b1;
    if0.in_valid = 1'b0;
    if0.in_data = '0;
    tick;
    reset = 1'b0;
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_flight_valid: got %b expected 0", if0.out_valid); end
    checks++; if (if0.partial_sum !== 32'd0) begin errors++; $display("FAIL rst_flight_sum: got %0d expected 0", if0.partial_sum); end
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_after_valid_%0d: got %b expected 0", k, if0.out_valid); end
      checks++; if (if0.partial_sum !== 32'd0) begin errors++; $display("FAIL rst_after_sum_%0d: got %0d expected 0", k, if0.partial_sum); end
    end
  endtask

  task automatic test_meta_dup;
    logic signed [31:0] ps;
    logic ov, ove;
    // both lanes read element 3 (=7): 2*7 + 1*7 + 5
    load_w0(8'sd2, 8'sd1, 2'd3, 2'd3);
    run_one({8'd7, 8'd3, 8'd2, 8'd1}, 32'sd5, ps, ov, ove);
    checks++; if (ps !== 32'sd26) begin errors++; $display("FAIL meta_dup_sum: got %0d expected 26", ps); end
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL meta_dup_valid: got %b expected 1", ov); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_all;
    test_reset;
    test_basic;
    test_extremes;
    test_saturation;
    test_stall;
    test_double_buffer;
    test_reset_inflight;
    test_meta_dup;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
